// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS fetch/decode front end: opcodes, funct codes,
// one-hot instruction indices, next-PC selects and the fetch FSM states.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // One-hot bit positions in the ins vector
    localparam int INS_ADD   = 0;
    localparam int INS_ADDU  = 1;
    localparam int INS_SUB   = 2;
    localparam int INS_SUBU  = 3;
    localparam int INS_AND   = 4;
    localparam int INS_OR    = 5;
    localparam int INS_XOR   = 6;
    localparam int INS_NOR   = 7;
    localparam int INS_SLT   = 8;
    localparam int INS_SLTU  = 9;
    localparam int INS_SLL   = 10;
    localparam int INS_SRL   = 11;
    localparam int INS_SRA   = 12;
    localparam int INS_SLLV  = 13;
    localparam int INS_SRLV  = 14;
    localparam int INS_SRAV  = 15;
    localparam int INS_JR    = 16;
    localparam int INS_ADDI  = 17;
    localparam int INS_ADDIU = 18;
    localparam int INS_ANDI  = 19;
    localparam int INS_ORI   = 20;
    localparam int INS_XORI  = 21;
    localparam int INS_LW    = 22;
    localparam int INS_SW    = 23;
    localparam int INS_BEQ   = 24;
    localparam int INS_BNE   = 25;
    localparam int INS_SLTI  = 26;
    localparam int INS_SLTIU = 27;
    localparam int INS_LUI   = 28;
    localparam int INS_J     = 29;
    localparam int INS_JAL   = 30;

    // Next-PC select from the control unit
    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_JR  = 2'b01;
    localparam logic [1:0] PCSEL_BR  = 2'b10;
    localparam logic [1:0] PCSEL_J   = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // Branch displacement: sign-extended word offset converted to bytes.
    function automatic logic signed [31:0] br_offset(input logic [15:0] imm);
        logic signed [31:0] off;
        off = {{14{imm[15]}}, imm, 2'b00};
        return off;
    endfunction

endpackage

// File: rtl/ins_decoder.sv
// Combinational MIPS pre-decode: instruction word to one-hot ins vector.
// An all-zero result marks an unsupported opcode/funct combination.
module ins_decoder
    import mips_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] ins
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = word[31:26];
    assign funct  = word[5:0];
    // rs/rt/rd/shamt and immediates do not affect the class of the instruction
    assign unused_fields = ^word[25:6];

    always_comb begin
        ins = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ins[INS_ADD]  = 1'b1;
                    FN_ADDU: ins[INS_ADDU] = 1'b1;
                    FN_SUB:  ins[INS_SUB]  = 1'b1;
                    FN_SUBU: ins[INS_SUBU] = 1'b1;
                    FN_AND:  ins[INS_AND]  = 1'b1;
                    FN_OR:   ins[INS_OR]   = 1'b1;
                    FN_XOR:  ins[INS_XOR]  = 1'b1;
                    FN_NOR:  ins[INS_NOR]  = 1'b1;
                    FN_SLT:  ins[INS_SLT]  = 1'b1;
                    FN_SLTU: ins[INS_SLTU] = 1'b1;
                    FN_SLL:  ins[INS_SLL]  = 1'b1;
                    FN_SRL:  ins[INS_SRL]  = 1'b1;
                    FN_SRA:  ins[INS_SRA]  = 1'b1;
                    FN_SLLV: ins[INS_SLLV] = 1'b1;
                    FN_SRLV: ins[INS_SRLV] = 1'b1;
                    FN_SRAV: ins[INS_SRAV] = 1'b1;
                    FN_JR:   ins[INS_JR]   = 1'b1;
                    default: ins = '0;
                endcase
            end
            OP_ADDI:  ins[INS_ADDI]  = 1'b1;
            OP_ADDIU: ins[INS_ADDIU] = 1'b1;
            OP_ANDI:  ins[INS_ANDI]  = 1'b1;
            OP_ORI:   ins[INS_ORI]   = 1'b1;
            OP_XORI:  ins[INS_XORI]  = 1'b1;
            OP_LW:    ins[INS_LW]    = 1'b1;
            OP_SW:    ins[INS_SW]    = 1'b1;
            OP_BEQ:   ins[INS_BEQ]   = 1'b1;
            OP_BNE:   ins[INS_BNE]   = 1'b1;
            OP_SLTI:  ins[INS_SLTI]  = 1'b1;
            OP_SLTIU: ins[INS_SLTIU] = 1'b1;
            OP_LUI:   ins[INS_LUI]   = 1'b1;
            OP_J:     ins[INS_J]     = 1'b1;
            OP_JAL:   ins[INS_JAL]   = 1'b1;
            default:  ins = '0;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch and pre-decode stage: owns the PC, runs the req/ack fetch,
// latches the word with its one-hot decode and commits the next PC.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [31:0]       instr,
    output logic [31:0]       ins,
    output logic              ins_valid,
    output logic              commit,
    output logic              illegal
);

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       ins_dec;
    logic [ADDR_W-1:0] next_pc;
    logic              fetch_done;
    logic              misaligned;
    logic              pc_load;

    ins_decoder u_dec (
        .word (imem_rdata),
        .ins  (ins_dec)
    );

    assign pc_plus4   = pc + ADDR_W'(4);
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc;
    assign ins_valid  = (state_q == ST_EXEC);
    assign commit     = ins_valid & ~stall;
    assign illegal    = (state_q == ST_HALT);
    assign fetch_done = (state_q == ST_FETCH) && imem_ack;
    assign misaligned = (next_pc[1:0] != 2'b00);
    assign pc_load    = commit && !misaligned;

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            PCSEL_SEQ: next_pc = pc_plus4;
            PCSEL_JR:  next_pc = rs_data;
            PCSEL_BR:  next_pc = pc_plus4 + $unsigned(br_offset(instr[15:0]));
            PCSEL_J:   next_pc = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
            default:   next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    // An undecodable word skips EXEC entirely
                    state_d = (ins_dec == '0) ? ST_HALT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    state_d = misaligned ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= '0;
            ins   <= '0;
        end else if (fetch_done) begin
            instr <= imem_rdata;
            ins   <= ins_dec;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch handshake, PC select paths, stall, faults, reset.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  pc_sel;
    logic [31:0] rs_data;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] ins;
    logic        ins_valid;
    logic        commit;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] W_ADDI = 32'h2008_0005;
    localparam logic [31:0] W_ADDU = 32'h0109_5021;
    localparam logic [31:0] W_BEQ  = 32'h1000_FFFF;
    localparam logic [31:0] W_JAL  = 32'h0C10_0010;
    localparam logic [31:0] W_JR   = 32'h03E0_0008;
    localparam logic [31:0] W_BAD  = 32'hFC00_0000;

    always #5 clk = ~clk;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_sel     (pc_sel),
        .rs_data    (rs_data),
        .stall      (stall),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr      (instr),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .commit     (commit),
        .illegal    (illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a request, inserts wait states, then acks with word.
    task automatic serve(input logic [31:0] word, input int waits);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL serve_timeout: imem_req=%b after %0d cycles, required 1", imem_req, n);
        end
        for (int i = 0; i < waits; i++) step();
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; pc_sel = 2'b00; rs_data = '0; stall = 1'b0;
        #2;
        checks++;
        if (pc !== RST_PC || imem_req !== 1'b0 || ins_valid !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: pc=%h req=%b vld=%b ill=%b, required %h 0 0 0", pc, imem_req, ins_valid, illegal, RST_PC);
        end
        checks++;
        if (ins !== 32'h0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: ins=%h instr=%h, required 0 0", ins, instr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_fetch: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_basic_fetch();
        serve(W_ADDI, 0);
        checks++;
        if (ins_valid !== 1'b1 || ins !== (32'h1 << 17) || instr !== W_ADDI) begin
            errors++;
            $display("FAIL addi_decode: vld=%b ins=%h instr=%h, required 1 %h %h", ins_valid, ins, instr, 32'h1 << 17, W_ADDI);
        end
        checks++;
        if (commit !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL addi_commit: commit=%b req=%b, required 1 0", commit, imem_req);
        end
        pc_sel = 2'b00;
        step();
        checks++;
        if (ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin
            errors++;
            $display("FAIL seq_next: vld=%b req=%b addr=%h, required 0 1 00400004", ins_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004 || ins_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold%0d: req=%b addr=%h vld=%b, required 1 00400004 0", i, imem_req, imem_addr, ins_valid);
            end
            if (i < 3) step();
        end
        imem_ack = 1'b1; imem_rdata = W_ADDU;
        step();
        imem_ack = 1'b0; imem_rdata = '0;
        checks++;
        if (ins_valid !== 1'b1 || ins !== 32'h0000_0002) begin
            errors++;
            $display("FAIL wait_decode: vld=%b ins=%h, required 1 00000002", ins_valid, ins);
        end
        step();
    endtask

    task automatic run_nops(input int n);
        for (int i = 0; i < n; i++) begin
            serve(32'h0, 0);
            checks++;
            if (ins_valid !== 1'b1 || ins !== (32'h1 << 10)) begin
                errors++;
                $display("FAIL nop_decode: vld=%b ins=%h, required 1 %h", ins_valid, ins, 32'h1 << 10);
            end
            pc_sel = 2'b00;
            step();
        end
    endtask

    task automatic test_branch();
        serve(W_BEQ, 0);
        checks++;
        if (ins !== (32'h1 << 24) || pc !== 32'h0040_0010) begin
            errors++;
            $display("FAIL beq_decode: ins=%h pc=%h, required %h 00400010", ins, pc, 32'h1 << 24);
        end
        pc_sel = 2'b10;
        step();
        checks++;
        if (pc !== 32'h0040_0010 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken: pc=%h req=%b, required 00400010 1", pc, imem_req);
        end
        serve(W_BEQ, 0);
        pc_sel = 2'b00;
        step();
        checks++;
        if (pc !== 32'h0040_0014) begin
            errors++;
            $display("FAIL beq_not_taken: pc=%h, required 00400014", pc);
        end
    endtask

    task automatic test_jump();
        serve(W_JAL, 0);
        checks++;
        if (ins !== (32'h1 << 30) || pc_plus4 !== 32'h0040_0024) begin
            errors++;
            $display("FAIL jal_exec: ins=%h pc_plus4=%h, required %h 00400024", ins, pc_plus4, 32'h1 << 30);
        end
        pc_sel = 2'b11;
        step();
        checks++;
        if (pc !== 32'h0040_0040) begin
            errors++;
            $display("FAIL jal_target: pc=%h, required 00400040", pc);
        end
        serve(W_JR, 0);
        checks++;
        if (ins !== (32'h1 << 16)) begin
            errors++;
            $display("FAIL jr_decode: ins=%h, required %h", ins, 32'h1 << 16);
        end
        rs_data = 32'h0040_0100;
        pc_sel  = 2'b01;
        step();
        checks++;
        if (pc !== 32'h0040_0100) begin
            errors++;
            $display("FAIL jr_target: pc=%h, required 00400100", pc);
        end
        pc_sel = 2'b00;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        serve(W_ADDI, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (commit !== 1'b0 || ins_valid !== 1'b1 || pc !== 32'h0040_0100 || ins !== (32'h1 << 17)) begin
                errors++;
                $display("FAIL stall_hold%0d: commit=%b vld=%b pc=%h ins=%h, required 0 1 00400100 %h", i, commit, ins_valid, pc, ins, 32'h1 << 17);
            end
            if (i == 1) begin
                imem_ack = 1'b1; imem_rdata = W_BAD;
            end
            step();
            imem_ack = 1'b0; imem_rdata = '0;
        end
        checks++;
        if (instr !== W_ADDI) begin
            errors++;
            $display("FAIL ack_outside_fetch: instr=%h, required %h", instr, W_ADDI);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (commit !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: commit=%b, required 1", commit);
        end
        step();
        checks++;
        if (pc !== 32'h0040_0104 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_advance: pc=%h req=%b, required 00400104 1", pc, imem_req);
        end
    endtask

    task automatic test_misaligned();
        serve(W_JR, 0);
        rs_data = 32'h0040_0102;
        pc_sel  = 2'b01;
        step();
        checks++;
        if (illegal !== 1'b1 || pc !== 32'h0040_0104 || ins_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_halt: ill=%b pc=%h vld=%b req=%b, required 1 00400104 0 0", illegal, pc, ins_valid, imem_req);
        end
        pc_sel = 2'b00;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (illegal !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0040_0104) begin
            errors++;
            $display("FAIL misaligned_sticky: ill=%b req=%b pc=%h, required 1 0 00400104", illegal, imem_req, pc);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        checks++;
        if (illegal !== 1'b0 || imem_req !== 1'b1 || pc !== RST_PC) begin
            errors++;
            $display("FAIL halt_exit: ill=%b req=%b pc=%h, required 0 1 %h", illegal, imem_req, pc, RST_PC);
        end
        serve(W_BAD, 0);
        checks++;
        if (illegal !== 1'b1 || ins_valid !== 1'b0 || instr !== W_BAD || ins !== 32'h0 || pc !== RST_PC) begin
            errors++;
            $display("FAIL illegal_op: ill=%b vld=%b instr=%h ins=%h pc=%h, required 1 0 %h 0 %h", illegal, ins_valid, instr, ins, pc, W_BAD, RST_PC);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_req !== 1'b0 || illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_no_req%0d: req=%b ill=%b, required 0 1", i, imem_req, illegal);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        serve(W_ADDI, 0);
        pc_sel = 2'b00;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin
            errors++;
            $display("FAIL pre_reset_fetch: req=%b addr=%h, required 1 00400004", imem_req, imem_addr);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== RST_PC || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pc=%h req=%b, required %h 0", pc, imem_req, RST_PC);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL post_reset_fetch: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_wait_states();
        run_nops(2);
        test_branch();
        run_nops(3);
        test_jump();
        test_stall();
        test_misaligned();
        test_illegal();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch and pre-decode stage of the 31-instruction MIPS CPU, placed directly upstream of the control unit.
- Owns the PC register and runs a req/ack fetch from instruction memory, which may insert wait states.
- Latches each fetched word and presents it as a one-hot `ins` vector for the control unit to consume.
- Consumes the control unit's 2-bit next-PC select to commit the next PC.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset
ADDR_W, 32, PC/address width; fixed at 32, other values unsupported

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, held until ack
imem_addr  out  32  fetch address; equals pc while imem_req=1
imem_ack  in  1  one-cycle strobe; imem_rdata valid in the same cycle
imem_rdata  in  32  instruction word
pc_sel  in  2  next-PC select from control: 00 pc+4, 01 jr (rs_data), 10 branch taken, 11 j/jal
rs_data  in  32  GPR[rs], jr target
stall  in  1  hold current instruction in EXEC
pc  out  32  address of the current instruction
pc_plus4  out  32  pc+4, used for the jal link
instr  out  32  latched instruction word
ins  out  32  one-hot decode (bit map below); bit 31 always 0
ins_valid  out  1  instr/ins valid (EXEC state)
commit  out  1  ins_valid & ~stall; the cycle in which RF/DM writes and the PC update take effect
illegal  out  1  sticky halt flag

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC; instr=0; ins=0; ins_valid=0; imem_req=0; illegal=0; state=RESET.
  - An in-flight fetch is abandoned; instruction memory must tolerate a dropped request.
- States: RESET, FETCH, EXEC, HALT.
- RESET -> FETCH on the first clock edge after rst deasserts.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: latch instr=imem_rdata, latch the registered ins decode, go to EXEC.
  - imem_ack outside FETCH is ignored.
- Minimum latency: ack in cycle N -> ins_valid=1 in cycle N+1.
- EXEC: ins_valid=1; imem_req=0.
  - While stall=1: hold state, pc, instr and ins.
  - When stall=0 (commit=1): pc <= next_pc, go to FETCH.
  - Sequencing: one instruction per fetch; minimum 2 cycles per instruction.
- next_pc (all arithmetic mod 2^32):
  - 00: pc+4
  - 01: rs_data
  - 10: pc+4 + (sign_extend(instr[15:0])<<2)
  - 11: {pc_plus4[31:28], instr[25:0], 2'b00}
- Fault -> HALT, illegal=1; pc and instr are held at the faulting instruction; only rst exits HALT:
  - Decoded ins==0 (unknown opcode/funct): the word is still latched, the EXEC cycle is skipped, go straight to HALT.
  - In EXEC with commit=1 and next_pc[1:0]!=0 (misaligned target, any pc_sel): pc is not updated.
- One-hot map.
  - R-type, opcode=0, by funct:
    - 0 add 20h, 1 addu 21h, 2 sub 22h, 3 subu 23h
    - 4 and 24h, 5 or 25h, 6 xor 26h, 7 nor 27h
    - 8 slt 2Ah, 9 sltu 2Bh
    - 10 sll 00h, 11 srl 02h, 12 sra 03h, 13 sllv 04h, 14 srlv 06h, 15 srav 07h
    - 16 jr 08h
  - By opcode:
    - 17 addi 08h, 18 addiu 09h, 19 andi 0Ch, 20 ori 0Dh, 21 xori 0Eh
    - 22 lw 23h, 23 sw 2Bh, 24 beq 04h, 25 bne 05h
    - 26 slti 0Ah, 27 sltiu 0Bh, 28 lui 0Fh
    - 29 j 02h, 30 jal 03h
  - Decode checks opcode and funct only (shamt/rs fields are not checked).
  - Word 0x0000_0000 decodes as sll (nop) and is legal.

Decomposition:
- Package mips_pkg holds:
  - opcode/funct localparams
  - one-hot index constants INS_ADD..INS_JAL
  - pc_sel encodings PCSEL_SEQ/JR/BR/J
  - state encoding
  - RESET_PC default
- Sub-module ins_decoder: purely combinational 32-bit word -> 32-bit one-hot; shared with the verification reference model.
- if_stage holds the FSM, PC, instr/ins registers and the next_pc mux.

Test Plan:
- rst released; memory acks after 0 wait states -> imem_addr=0x00400000; instr 0x20080005 (addi) -> ins=1<<17, ins_valid for 1 cycle, next imem_addr=0x00400004.
- 3 wait states before ack -> imem_req held high for 4 cycles with a stable address; ins_valid asserts in the cycle after the ack.
- beq at 0x00400010, imm=0xFFFF, pc_sel=10 -> next pc=0x00400010. Same with pc_sel=00 -> 0x00400014.
- jal 0x0C100010 at 0x00400020, pc_sel=11 -> pc=0x00400040, pc_plus4 during EXEC=0x00400024. jr with rs_data=0x00400100, pc_sel=01 -> pc=0x00400100.
- stall high for 3 EXEC cycles -> ins/pc stable and commit=0; commit=1 only in the cycle stall drops.
- Faults and reset:
  - Word 0xFC000000 -> illegal=1, state HALT, no further imem_req.
  - jr with rs_data=0x00400102 -> HALT, pc unchanged.
  - rst pulsed mid-FETCH -> pc=0x00400000 and imem_req=0 immediately, without waiting for a clock edge.
